// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM states, port identifiers and default timeout shared by the arbiter files
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;
    localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// arb_select: combinational winner pick between the fetch and load/store requests
module arb_select
    import mem_port_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic rr_ptr,
    output logic any_req,
    output logic winner
);
    // contention goes to the pointer port, otherwise the lone requester wins
    always_comb begin
        any_req = if_req | ls_req;
        winner  = (if_req && ls_req) ? rr_ptr : (ls_req ? PORT_LS : PORT_IF);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch and load/store ports sharing one single-outstanding memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    state_t     state;
    logic       owner;
    logic [7:0] wait_cnt;
    logic       any_req;
    logic       winner;
    logic       rr_ptr;

`ifndef MEM_ARB_RR_EN
    assign rr_ptr = PORT_LS;
`endif

    arb_select u_sel (
        .if_req  (if_req),
        .ls_req  (ls_req),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    // grant in IDLE, run the access with a timeout, present the response for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= PORT_IF;
            wait_cnt  <= '0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr    <= PORT_LS;
`endif
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    state     <= ACCESS;
                    owner     <= winner;
                    wait_cnt  <= '0;
                    if_gnt    <= winner == PORT_IF;
                    ls_gnt    <= winner == PORT_LS;
                    mem_req   <= 1'b1;
                    mem_we    <= winner == PORT_LS && ls_we;
                    mem_be    <= winner == PORT_LS ? ls_be : 4'hF;
                    mem_addr  <= winner == PORT_LS ? ls_addr : if_addr;
                    mem_wdata <= winner == PORT_LS ? ls_wdata : 32'h0;
`ifdef MEM_ARB_RR_EN
                    rr_ptr    <= ~winner;
`endif
                end
                ACCESS: if (mem_ready) begin
                    state     <= RESP;
                    mem_req   <= 1'b0;
                    rsp_rdata <= mem_rdata;
                    rsp_err   <= 1'b0;
                    if_rvalid <= owner == PORT_IF;
                    ls_rvalid <= owner == PORT_LS;
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    state     <= RESP;
                    mem_req   <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                    if_rvalid <= owner == PORT_IF;
                    ls_rvalid <= owner == PORT_LS;
                end else begin
                    wait_cnt  <= wait_cnt + 8'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter
Interface
REQ-001 Parameter TIMEOUT, default 255, ACCESS-state cycles without mem_ready before error (1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch request; held until if_gnt.
REQ-005 if_addr  input  32  fetch word address; stable while if_req high.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 if_rvalid  output  1  one-cycle pulse: fetch response on rsp_rdata/rsp_err.
REQ-008 ls_req  input  1  load/store request; held until ls_gnt.
REQ-009 ls_we  input  1  1 = store, 0 = load.
REQ-010 ls_be  input  4  store byte enables.
REQ-011 ls_addr  input  32  load/store address.
REQ-012 ls_wdata  input  32  store data.
REQ-013 ls_gnt  output  1  one-cycle pulse: load/store accepted.
REQ-014 ls_rvalid  output  1  one-cycle pulse: load data or store ack.
REQ-015 rsp_rdata  output  32  shared response data, meaningful only with if_rvalid or ls_rvalid.
REQ-016 rsp_err  output  1  response is a timeout error; qualified by rvalid.
REQ-017 mem_req  output  1  memory access active; held high through ACCESS.
REQ-018 mem_we, mem_be[3:0], mem_addr[31:0], mem_wdata[31:0]  outputs  registered copy of granted request; fetch drives we=0, be=4'hF, wdata=0.
REQ-019 mem_rdata  input  32  read data, sampled when mem_ready high.
REQ-020 mem_ready  input  1  memory completes current access this cycle.
Function
REQ-021 FSM states IDLE, ACCESS, RESP; single outstanding access.
REQ-022 IDLE: if any req sampled high at edge N, winner latched, state ACCESS at N+1, winner gnt high during cycle N+1 only.
REQ-023 Fixed priority (macro absent): ls_req wins over if_req on simultaneous requests.
REQ-024 ACCESS: mem_req=1; edge with mem_ready=1 captures mem_rdata into rsp_rdata, clears rsp_err, goes RESP.
REQ-025 ACCESS: 8-bit wait counter increments each cycle mem_ready=0; reaching TIMEOUT goes RESP with rsp_err=1, rsp_rdata=0, mem_req dropped.
REQ-026 RESP: owner rvalid high exactly one cycle, then IDLE; rsp_rdata/rsp_err hold until next response.
REQ-027 Minimum latency: req at N, gnt N+1, mem_ready in N+1, rvalid N+2, next grant N+4.
REQ-028 Loser of simultaneous request keeps req high and is granted at the next IDLE evaluation; no request is dropped.
REQ-029 Stores return ls_rvalid with rsp_rdata = mem_rdata as acknowledge.
REQ-030 if_gnt and ls_gnt never high together; if_rvalid and ls_rvalid never high together.
REQ-031 req deasserted before gnt: behaviour unspecified; bench shall not drive it.
Reset
REQ-032 rst_n low: state IDLE, all gnt/rvalid/mem_req/mem_we/rsp_err 0, mem_be/mem_addr/mem_wdata/rsp_rdata 0, wait counter 0, RR pointer = ls.
REQ-033 Reset mid-ACCESS abandons the access immediately with no rvalid; first post-reset grant follows REQ-022.
Configuration
REQ-034 MEM_ARB_RR_EN defined: round-robin; after each grant pointer moves to the other port, simultaneous requests go to pointer port.
REQ-035 MEM_ARB_RR_EN undefined: fixed ls-over-if priority, no pointer register.
Structure
REQ-036 Shared package holds state enum (IDLE/ACCESS/RESP), port-ID constants (PORT_IF=0, PORT_LS=1), default TIMEOUT.
REQ-037 One sub-module, arb_select: combinational winner pick from requests plus RR pointer.
Verification
REQ-038 Lone if_req addr 0x100, mem_ready in first ACCESS cycle, mem_rdata 0x00000013 -> if_gnt at N+1, if_rvalid at N+2, rsp_rdata 0x00000013.
REQ-039 Simultaneous if_req and ls_req (load 0x2000), macro absent -> ls served first, if granted at N+4; two rvalids, no overlap.
REQ-040 Same stimulus with MEM_ARB_RR_EN, both held for 4 transactions -> grants alternate ls, if, ls, if.
REQ-041 Store ls_be=4'b0011 wdata 0xDEADBEEF addr 0x40, 3 wait cycles -> mem_we=1, mem_be=0011 held 4 cycles, ls_rvalid after mem_ready.
REQ-042 mem_ready held low, TIMEOUT=4 -> rvalid with rsp_err=1, rsp_rdata=0 after 4 ACCESS cycles; mem_req low in RESP.
REQ-043 rst_n pulsed low during ACCESS -> all outputs 0 asynchronously, no rvalid; subsequent if_req completes normally.
